// File: rtl/jtag_ir_dr_path_if.sv
// -----------------------------------------------------------------------------
// jtag_ir_dr_path_if
// Bundles the TAP-controller strobes, serial data and the datapath results
// between the TAP FSM (master) and the IR/DR datapath (slave).
//   TDI                   serial test data in
//   CAPTURE_IR/SHIFT_IR/UPDATE_IR   IR strobes from the TAP FSM
//   CAPTURE_DR/SHIFT_DR/UPDATE_DR   DR strobes from the TAP FSM
//   IR_OUT                current (updated) instruction
//   TDR_SELECT            1 = user TDR selected, 0 = bypass
//   TDR_OUT               parallel output of the TDR update stage
//   TDO                   serial test data out
// -----------------------------------------------------------------------------
interface jtag_ir_dr_path_if #(
  parameter int unsigned IR_WIDTH  = 5,
  parameter int unsigned TDR_WIDTH = 8
);
  logic                 TDI;
  logic                 CAPTURE_IR;
  logic                 SHIFT_IR;
  logic                 UPDATE_IR;
  logic                 CAPTURE_DR;
  logic                 SHIFT_DR;
  logic                 UPDATE_DR;
  logic [IR_WIDTH-1:0]  IR_OUT;
  logic                 TDR_SELECT;
  logic [TDR_WIDTH-1:0] TDR_OUT;
  logic                 TDO;

  modport master (
    output TDI, CAPTURE_IR, SHIFT_IR, UPDATE_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR,
    input  IR_OUT, TDR_SELECT, TDR_OUT, TDO
  );

  modport slave (
    input  TDI, CAPTURE_IR, SHIFT_IR, UPDATE_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR,
    output IR_OUT, TDR_SELECT, TDR_OUT, TDO
  );
endinterface

// File: rtl/jtag_ir_dr_path.sv
// -----------------------------------------------------------------------------
// jtag_ir_dr_path
// JTAG instruction/data register datapath sitting between the TAP FSM and the
// TDO pin: 5-bit IR (shift + update stage), opcode decoder, 8-bit user TDR or
// 1-bit bypass on the DR path, and final TDO gating.
// Ports:
//   TCK     test clock, all state changes on the rising edge
//   TRST_N  synchronous active-low reset, sampled on rising TCK
//   jif     jtag_ir_dr_path_if.slave (strobes, TDI, IR_OUT, TDR_SELECT,
//           TDR_OUT, TDO)
// Optional feature macro: IDCODE_EN -- adds a 32-bit IDCODE register selected
// by opcode 5'b00001, which also becomes the IR reset value.
// -----------------------------------------------------------------------------
module jtag_ir_dr_path #(
  parameter int unsigned          IR_WIDTH      = 5,
  parameter int unsigned          TDR_WIDTH     = 8,
  parameter logic [IR_WIDTH-1:0]  TDR_OPCODE    = IR_WIDTH'(5'b00010),
  parameter logic [IR_WIDTH-1:0]  BYPASS_OPCODE = IR_WIDTH'(5'b11111)
`ifdef IDCODE_EN
  , parameter logic [31:0]        IDCODE_VALUE  = 32'h1000_0001
`endif
) (
  input  logic           TCK,
  input  logic           TRST_N,
  jtag_ir_dr_path_if.slave jif
);

  // Capture pattern: "01" in the two LSBs as required by IEEE 1149.1
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

`ifdef IDCODE_EN
  localparam int unsigned         IDCODE_WIDTH  = 32;
  localparam logic [IR_WIDTH-1:0] IDCODE_OPCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_RESET      = IDCODE_OPCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET      = BYPASS_OPCODE;
`endif

  logic [IR_WIDTH-1:0]  ir_shift;
  logic [IR_WIDTH-1:0]  ir_out;
  logic [TDR_WIDTH-1:0] tdr_shift;
  logic [TDR_WIDTH-1:0] tdr_out;
  logic                 byp_bit;

  logic ir_cap, ir_shf, ir_upd;
  logic dr_cap, dr_shf, dr_upd;
  logic tdr_sel, byp_sel, dr_so;

`ifdef IDCODE_EN
  logic [IDCODE_WIDTH-1:0] idcode_shift;
  logic                    idcode_sel;
`endif

  // Strobe priority capture > shift > update, applied across IR and DR strobes
  always_comb begin
    ir_cap = 1'b0;
    ir_shf = 1'b0;
    ir_upd = 1'b0;
    dr_cap = 1'b0;
    dr_shf = 1'b0;
    dr_upd = 1'b0;
    if (jif.CAPTURE_IR || jif.CAPTURE_DR) begin
      ir_cap = jif.CAPTURE_IR;
      dr_cap = jif.CAPTURE_DR;
    end else if (jif.SHIFT_IR || jif.SHIFT_DR) begin
      ir_shf = jif.SHIFT_IR;
      dr_shf = jif.SHIFT_DR;
    end else begin
      ir_upd = jif.UPDATE_IR;
      dr_upd = jif.UPDATE_DR;
    end
  end

  // Instruction decode; anything that is not a known opcode falls to bypass
  always_comb begin
    tdr_sel = (ir_out == TDR_OPCODE);
`ifdef IDCODE_EN
    idcode_sel = (ir_out == IDCODE_OPCODE);
    byp_sel    = !tdr_sel && !idcode_sel;
`else
    byp_sel    = !tdr_sel;
`endif
  end

  // Instruction register: shift stage plus update stage
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      ir_shift <= IR_CAPTURE;
      ir_out   <= IR_RESET;
    end else if (ir_cap) begin
      ir_shift <= IR_CAPTURE;
    end else if (ir_shf) begin
      ir_shift <= {jif.TDI, ir_shift[IR_WIDTH-1:1]};
    end else if (ir_upd) begin
      ir_out   <= ir_shift;
    end
  end

  // User test data register; readback of the update stage on capture
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      tdr_shift <= '0;
      tdr_out   <= '0;
    end else if (tdr_sel) begin
      if (dr_cap) begin
        tdr_shift <= tdr_out;
      end else if (dr_shf) begin
        tdr_shift <= {jif.TDI, tdr_shift[TDR_WIDTH-1:1]};
      end else if (dr_upd) begin
        tdr_out   <= tdr_shift;
      end
    end
  end

  // Bypass bit: captures 0, one-cycle TDI->TDO delay while shifting
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      byp_bit <= 1'b0;
    end else if (byp_sel) begin
      if (dr_cap) begin
        byp_bit <= 1'b0;
      end else if (dr_shf) begin
        byp_bit <= jif.TDI;
      end
    end
  end

`ifdef IDCODE_EN
  // IDCODE register: capture-only, update has no effect
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      idcode_shift <= '0;
    end else if (idcode_sel) begin
      if (dr_cap) begin
        idcode_shift <= IDCODE_VALUE;
      end else if (dr_shf) begin
        idcode_shift <= {jif.TDI, idcode_shift[IDCODE_WIDTH-1:1]};
      end
    end
  end
`endif

  // DR serial-out mux
  always_comb begin
    dr_so = byp_bit;
    if (tdr_sel) begin
      dr_so = tdr_shift[0];
    end
`ifdef IDCODE_EN
    if (idcode_sel) begin
      dr_so = idcode_shift[0];
    end
`endif
  end

  assign jif.IR_OUT     = ir_out;
  assign jif.TDR_SELECT = tdr_sel;
  assign jif.TDR_OUT    = tdr_out;
  // TDO is forced low outside the shift states; no tri-state on this path
  assign jif.TDO        = (jif.SHIFT_IR & ir_shift[0]) | (jif.SHIFT_DR & dr_so);

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// -----------------------------------------------------------------------------
// tb_jtag_ir_dr_path
// Self-checking bench for jtag_ir_dr_path. Expected TDO bits are queued when a
// cycle is driven and popped when that cycle's TDO is sampled; parallel
// outputs are compared against constants from the test plan.
// -----------------------------------------------------------------------------
module tb_jtag_ir_dr_path;

  localparam int unsigned IR_WIDTH  = 5;
  localparam int unsigned TDR_WIDTH = 8;

  // Strobe encoding {CAPTURE_IR, SHIFT_IR, UPDATE_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_CIR  = 6'b100000;
  localparam logic [5:0] S_SIR  = 6'b010000;
  localparam logic [5:0] S_UIR  = 6'b001000;
  localparam logic [5:0] S_CDR  = 6'b000100;
  localparam logic [5:0] S_SDR  = 6'b000010;
  localparam logic [5:0] S_UDR  = 6'b000001;

`ifdef IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RST_EXP = 5'b00001;
`else
  localparam logic [IR_WIDTH-1:0] IR_RST_EXP = 5'b11111;
`endif

  logic tck = 1'b0;
  logic trst_n = 1'b0;

  jtag_ir_dr_path_if #(.IR_WIDTH(IR_WIDTH), .TDR_WIDTH(TDR_WIDTH)) jif ();

  jtag_ir_dr_path dut (
    .TCK    (tck),
    .TRST_N (trst_n),
    .jif    (jif)
  );

  always #5 tck = ~tck;

  logic        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One TCK cycle: drive at negedge, optionally compare TDO against the queue,
  // then step past the rising edge.
  task automatic cycle(input logic [5:0] s, input logic tdi, input logic rst_n, input logic sample);
    logic e;
    @(negedge tck);
    trst_n         = rst_n;
    jif.TDI        = tdi;
    jif.CAPTURE_IR = s[5];
    jif.SHIFT_IR   = s[4];
    jif.UPDATE_IR  = s[3];
    jif.CAPTURE_DR = s[2];
    jif.SHIFT_DR   = s[1];
    jif.UPDATE_DR  = s[0];
    #1;
    if (sample) begin
      if (exp_q.size() == 0) begin
        check("tdo_queue_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tdo", 32'(jif.TDO), 32'(e));
      end
    end
    @(posedge tck);
    #1;
  endtask

  // Capture, shift in an opcode LSB-first, update; TDO must show the capture pattern
  task automatic load_ir(input logic [IR_WIDTH-1:0] op);
    logic [IR_WIDTH-1:0] cap_pat;
    cap_pat = 5'b00001;
    cycle(S_CIR, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < int'(IR_WIDTH); i++) begin
      exp_q.push_back(cap_pat[i]);
      cycle(S_SIR, op[i], 1'b1, 1'b1);
    end
    cycle(S_UIR, 1'b0, 1'b1, 1'b0);
  endtask

  // Capture, shift 8 bits LSB-first expecting prior TDR_OUT on TDO, update
  task automatic shift_tdr(input logic [TDR_WIDTH-1:0] din, input logic [TDR_WIDTH-1:0] old);
    cycle(S_CDR, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < int'(TDR_WIDTH); i++) begin
      exp_q.push_back(old[i]);
      cycle(S_SDR, din[i], 1'b1, 1'b1);
    end
    cycle(S_UDR, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    jif.TDI = 1'b0;
    jif.CAPTURE_IR = 1'b0; jif.SHIFT_IR = 1'b0; jif.UPDATE_IR = 1'b0;
    jif.CAPTURE_DR = 1'b0; jif.SHIFT_DR = 1'b0; jif.UPDATE_DR = 1'b0;

    // Reset for two cycles
    exp_q.push_back(1'b0);
    cycle(S_NONE, 1'b1, 1'b0, 1'b1);
    cycle(S_NONE, 1'b0, 1'b0, 1'b0);
    cycle(S_NONE, 1'b0, 1'b1, 1'b0);
    check("rst_ir_out",     32'(jif.IR_OUT),     32'(IR_RST_EXP));
    check("rst_tdr_select", 32'(jif.TDR_SELECT), 32'd0);
    check("rst_tdr_out",    32'(jif.TDR_OUT),    32'h00);
    check("rst_tdo",        32'(jif.TDO),        32'd0);

`ifdef IDCODE_EN
    // IDCODE selected out of reset: 32-bit readback LSB-first
    begin
      logic [31:0] idv;
      idv = 32'h1000_0001;
      cycle(S_CDR, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 32; i++) begin
        exp_q.push_back(idv[i]);
        cycle(S_SDR, 1'b0, 1'b1, 1'b1);
      end
    end
`endif

    // Select the TDR
    load_ir(5'b00010);
    check("ir_load_ir_out",     32'(jif.IR_OUT),     32'h02);
    check("ir_load_tdr_select", 32'(jif.TDR_SELECT), 32'd1);

    // TDR write and readback
    shift_tdr(8'hA5, 8'h00);
    check("tdr_write_a5", 32'(jif.TDR_OUT), 32'hA5);
    shift_tdr(8'h3C, 8'hA5);
    check("tdr_write_3c", 32'(jif.TDR_OUT), 32'h3C);

    // Bypass: one-cycle delay, TDR untouched
    load_ir(5'b11111);
    check("byp_ir_out",     32'(jif.IR_OUT),     32'h1F);
    check("byp_tdr_select", 32'(jif.TDR_SELECT), 32'd0);
    exp_q.push_back(1'b0);
    cycle(S_CDR, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(1'b0);
    cycle(S_SDR, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(1'b1);
    cycle(S_SDR, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(1'b1);
    cycle(S_SDR, 1'b0, 1'b1, 1'b1);
    cycle(S_UDR, 1'b0, 1'b1, 1'b0);
    check("byp_tdr_out_kept", 32'(jif.TDR_OUT), 32'h3C);

    // No shift strobe: TDO held low while TDI toggles, nothing changes
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(1'b0);
      cycle(S_NONE, 1'(i % 2), 1'b1, 1'b1);
    end
    check("idle_ir_out",  32'(jif.IR_OUT),  32'h1F);
    check("idle_tdr_out", 32'(jif.TDR_OUT), 32'h3C);

    // CAPTURE_IR with SHIFT_IR: capture wins, IR shift stage becomes 00001.
    // TDO still reflects SHIFT_IR & old shift[0] (old stage = 11111).
    exp_q.push_back(1'b1);
    cycle(S_CIR | S_SIR, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < int'(IR_WIDTH); i++) begin
      exp_q.push_back(i == 0);
      cycle(S_SIR, 1'b1, 1'b1, 1'b1);
    end
    cycle(S_UIR, 1'b0, 1'b1, 1'b0);
    check("prio_ir_out", 32'(jif.IR_OUT), 32'h1F);

    // Reset in the middle of a TDR shift
    load_ir(5'b00010);
    check("mid_tdr_select_pre", 32'(jif.TDR_SELECT), 32'd1);
    cycle(S_CDR, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(1'b0);
    cycle(S_SDR, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(1'b0);
    cycle(S_SDR, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(1'b1);
    cycle(S_SDR, 1'b0, 1'b1, 1'b1);
    cycle(S_SDR, 1'b1, 1'b0, 1'b0);
    check("mid_rst_tdr_out",    32'(jif.TDR_OUT),    32'h00);
    check("mid_rst_ir_out",     32'(jif.IR_OUT),     32'(IR_RST_EXP));
    check("mid_rst_tdr_select", 32'(jif.TDR_SELECT), 32'd0);
    // DR register selected after reset was cleared: first shifted bit is 0
    exp_q.push_back(1'b0);
    cycle(S_SDR, 1'b1, 1'b1, 1'b1);
    cycle(S_NONE, 1'b0, 1'b1, 1'b0);

    check("tdo_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
